// File: rtl/stack_unit.sv
// Parametrised operand stack with PUSH/POP/REPL/DUP/SWAP/CLEAR commands,
// sticky error flags and registered top/next outputs for the ALU operand muxes.
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] stack_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] next,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    CMD_NOP   = 3'b000,
    CMD_PUSH  = 3'b001,
    CMD_POP   = 3'b010,
    CMD_REPL  = 3'b011,
    CMD_DUP   = 3'b100,
    CMD_SWAP  = 3'b101,
    CMD_CLEAR = 3'b110
  } cmd_e;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic [WIDTH-1:0] next_q, next_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             wrA, wrB;
  logic [AW-1:0]    idxA, idxB;
  logic [WIDTH-1:0] dataA, dataB;

  logic [AW-1:0]    cIdx, cm1, cm2, cm3;
  logic             isEmpty, isFull, lessTwo;

  assign cIdx    = count_q[AW-1:0];
  assign cm1     = cIdx - AW'(1);
  assign cm2     = cIdx - AW'(2);
  assign cm3     = cIdx - AW'(3);
  assign isEmpty = (count_q == '0);
  assign isFull  = (count_q == CW'(DEPTH));
  assign lessTwo = (count_q < CW'(2));

  // top/next are kept as shadow registers of the two highest entries so every
  // command resolves in one cycle; only POP needs a read of the third entry.
  always_comb begin
    count_d = count_q;
    top_d   = top_q;
    next_d  = next_q;
    ovf_d   = err_clr ? 1'b0 : ovf_q;
    unf_d   = err_clr ? 1'b0 : unf_q;
    wrA     = 1'b0;
    wrB     = 1'b0;
    idxA    = cIdx;
    idxB    = cm2;
    dataA   = stack_in;
    dataB   = top_q;

    case (cmd)
      CMD_PUSH: begin
        if (isFull) begin
          ovf_d = 1'b1;
        end else begin
          wrA     = 1'b1;
          count_d = count_q + CW'(1);
          top_d   = stack_in;
          next_d  = top_q;
        end
      end
      CMD_POP: begin
        if (isEmpty) begin
          unf_d = 1'b1;
        end else begin
          count_d = count_q - CW'(1);
          top_d   = next_q;
          next_d  = (count_q >= CW'(3)) ? mem[cm3] : '0;
        end
      end
      CMD_REPL: begin
        if (isEmpty) begin
          unf_d = 1'b1;
        end else begin
          wrA   = 1'b1;
          idxA  = cm1;
          top_d = stack_in;
        end
      end
      CMD_DUP: begin
        if (isEmpty) begin
          unf_d = 1'b1;
        end else if (isFull) begin
          ovf_d = 1'b1;
        end else begin
          wrA     = 1'b1;
          dataA   = top_q;
          count_d = count_q + CW'(1);
          next_d  = top_q;
        end
      end
      CMD_SWAP: begin
        if (lessTwo) begin
          unf_d = 1'b1;
        end else begin
          wrA    = 1'b1;
          idxA   = cm1;
          dataA  = next_q;
          wrB    = 1'b1;
          top_d  = next_q;
          next_d = top_q;
        end
      end
      CMD_CLEAR: begin
        count_d = '0;
        top_d   = '0;
        next_d  = '0;
      end
      default: begin
      end
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      top_q   <= '0;
      next_q  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      top_q   <= top_d;
      next_q  <= next_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is deliberately unreset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wrA) mem[idxA] <= dataA;
      if (wrB) mem[idxB] <= dataB;
    end
  end

  assign top       = top_q;
  assign next      = next_q;
  assign count     = count_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: directed scenarios plus a random command
// stream compared against a queue-based reference model.
module tb_stack_unit;

  localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010, REPL = 3'b011,
                         DUP = 3'b100, SWAP = 3'b101, CLR = 3'b110, NOP7 = 3'b111;
  localparam int DA = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] cmd = NOP;
  logic [7:0] stackIn = '0;
  logic       errClr = 1'b0;

  logic [7:0] topA, nextA, topB, nextB;
  logic [3:0] countA;
  logic [2:0] countB;
  logic       emptyA, fullA, ovfA, unfA, emptyB, fullB, ovfB, unfB;

  int nTests = 0;
  int nFail  = 0;

  logic [7:0] mq[$];
  logic       mOvf, mUnf;

  always #5 clk = ~clk;

  stack_unit #(.WIDTH(8), .DEPTH(8)) dutA (
    .clk(clk), .reset(reset), .cmd(cmd), .stack_in(stackIn), .err_clr(errClr),
    .top(topA), .next(nextA), .count(countA), .empty(emptyA), .full(fullA),
    .overflow(ovfA), .underflow(unfA)
  );

  stack_unit #(.WIDTH(8), .DEPTH(4)) dutB (
    .clk(clk), .reset(reset), .cmd(cmd), .stack_in(stackIn), .err_clr(errClr),
    .top(topB), .next(nextB), .count(countB), .empty(emptyB), .full(fullB),
    .overflow(ovfB), .underflow(unfB)
  );

  task automatic doCmd(input logic [2:0] c, input logic [7:0] d, input logic clr);
    cmd = c; stackIn = d; errClr = clr;
    @(posedge clk); #1;
    cmd = NOP; errClr = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1; cmd = PUSH; stackIn = 8'hAB; errClr = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; cmd = NOP;
  endtask

  // Reference model: queue back is top of stack.
  task automatic modelStep(input logic [2:0] c, input logic [7:0] d, input logic clr);
    logic eo, eu;
    logic [7:0] t;
    int n;
    eo = 1'b0; eu = 1'b0; n = mq.size();
    case (c)
      PUSH: if (n == DA) eo = 1'b1; else mq.push_back(d);
      POP:  if (n == 0) eu = 1'b1; else void'(mq.pop_back());
      REPL: if (n == 0) eu = 1'b1; else mq[n-1] = d;
      DUP:  if (n == 0) eu = 1'b1; else if (n == DA) eo = 1'b1; else mq.push_back(mq[n-1]);
      SWAP: if (n < 2) eu = 1'b1; else begin t = mq[n-1]; mq[n-1] = mq[n-2]; mq[n-2] = t; end
      CLR:  mq.delete();
      default: ;
    endcase
    mOvf = eo ? 1'b1 : (clr ? 1'b0 : mOvf);
    mUnf = eu ? 1'b1 : (clr ? 1'b0 : mUnf);
  endtask

  task automatic test_reset();
    doReset();
    nTests++; if (countA !== 4'd0) begin nFail++; $display("[TB] FAIL reset_count got %0d want 0", countA); end
    nTests++; if ({emptyA, fullA} !== 2'b10) begin nFail++; $display("[TB] FAIL reset_empty_full got %b want 10", {emptyA, fullA}); end
    nTests++; if ({topA, nextA} !== 16'h0000) begin nFail++; $display("[TB] FAIL reset_top_next got %h want 0000", {topA, nextA}); end
    nTests++; if ({ovfA, unfA} !== 2'b00) begin nFail++; $display("[TB] FAIL reset_flags got %b want 00", {ovfA, unfA}); end
  endtask

  task automatic test_push_pop();
    logic [7:0] wantTop [3];
    doReset();
    doCmd(PUSH, 8'h11, 1'b0); doCmd(PUSH, 8'h22, 1'b0); doCmd(PUSH, 8'h33, 1'b0);
    nTests++; if ({topA, nextA, countA} !== {8'h33, 8'h22, 4'd3}) begin
      nFail++; $display("[TB] FAIL push3 got top=%h next=%h count=%0d want 33 22 3", topA, nextA, countA); end
    wantTop[0] = 8'h22; wantTop[1] = 8'h11; wantTop[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      doCmd(POP, 8'h00, 1'b0);
      nTests++; if (topA !== wantTop[i]) begin
        nFail++; $display("[TB] FAIL pop%0d_top got %h want %h", i, topA, wantTop[i]); end
    end
    nTests++; if ({emptyA, countA, nextA} !== {1'b1, 4'd0, 8'h00}) begin
      nFail++; $display("[TB] FAIL pop_empty got empty=%b count=%0d next=%h want 1 0 00", emptyA, countA, nextA); end
  endtask

  task automatic test_swap_dup_repl();
    doReset();
    doCmd(PUSH, 8'h11, 1'b0); doCmd(PUSH, 8'h22, 1'b0);
    doCmd(SWAP, 8'h00, 1'b0);
    nTests++; if ({topA, nextA, countA} !== {8'h11, 8'h22, 4'd2}) begin
      nFail++; $display("[TB] FAIL swap got top=%h next=%h count=%0d want 11 22 2", topA, nextA, countA); end
    doCmd(DUP, 8'h00, 1'b0);
    nTests++; if ({topA, nextA, countA} !== {8'h11, 8'h11, 4'd3}) begin
      nFail++; $display("[TB] FAIL dup got top=%h next=%h count=%0d want 11 11 3", topA, nextA, countA); end
    doCmd(REPL, 8'h5A, 1'b0);
    nTests++; if ({topA, nextA, countA} !== {8'h5A, 8'h11, 4'd3}) begin
      nFail++; $display("[TB] FAIL repl got top=%h next=%h count=%0d want 5a 11 3", topA, nextA, countA); end
    doCmd(POP, 8'h00, 1'b0); doCmd(POP, 8'h00, 1'b0);
    nTests++; if ({topA, nextA, countA} !== {8'h22, 8'h00, 4'd1}) begin
      nFail++; $display("[TB] FAIL swap_mem got top=%h next=%h count=%0d want 22 00 1", topA, nextA, countA); end
  endtask

  task automatic test_full();
    doReset();
    for (int i = 1; i <= 4; i++) doCmd(PUSH, 8'(i), 1'b0);
    nTests++; if ({fullB, countB, ovfB} !== {1'b1, 3'd4, 1'b0}) begin
      nFail++; $display("[TB] FAIL full got full=%b count=%0d ovf=%b want 1 4 0", fullB, countB, ovfB); end
    doCmd(PUSH, 8'hFF, 1'b0);
    nTests++; if ({ovfB, topB, nextB, countB} !== {1'b1, 8'h04, 8'h03, 3'd4}) begin
      nFail++; $display("[TB] FAIL overflow_push got ovf=%b top=%h next=%h count=%0d want 1 04 03 4", ovfB, topB, nextB, countB); end
    doCmd(REPL, 8'h77, 1'b0);
    nTests++; if ({ovfB, unfB, topB, countB} !== {1'b1, 1'b0, 8'h77, 3'd4}) begin
      nFail++; $display("[TB] FAIL repl_full got ovf=%b unf=%b top=%h count=%0d want 1 0 77 4", ovfB, unfB, topB, countB); end
    doCmd(DUP, 8'h00, 1'b1);
    nTests++; if ({ovfB, topB, countB} !== {1'b1, 8'h77, 3'd4}) begin
      nFail++; $display("[TB] FAIL dup_full_clr got ovf=%b top=%h count=%0d want 1 77 4", ovfB, topB, countB); end
  endtask

  task automatic test_underflow();
    doReset();
    doCmd(POP, 8'h00, 1'b0);
    nTests++; if ({unfA, ovfA, countA} !== {1'b1, 1'b0, 4'd0}) begin
      nFail++; $display("[TB] FAIL pop_empty_unf got unf=%b ovf=%b count=%0d want 1 0 0", unfA, ovfA, countA); end
    doCmd(NOP, 8'h00, 1'b1);
    nTests++; if (unfA !== 1'b0) begin nFail++; $display("[TB] FAIL err_clr got unf=%b want 0", unfA); end
    doCmd(PUSH, 8'h3C, 1'b0);
    doCmd(SWAP, 8'h00, 1'b0);
    nTests++; if ({unfA, topA, countA} !== {1'b1, 8'h3C, 4'd1}) begin
      nFail++; $display("[TB] FAIL swap_one got unf=%b top=%h count=%0d want 1 3c 1", unfA, topA, countA); end
    doCmd(SWAP, 8'h00, 1'b1);
    nTests++; if (unfA !== 1'b1) begin nFail++; $display("[TB] FAIL swap_clr_setwins got unf=%b want 1", unfA); end
  endtask

  task automatic test_clear_reset();
    doReset();
    for (int i = 0; i < 5; i++) doCmd(PUSH, 8'(8'hA0 + i), 1'b0);
    doCmd(CLR, 8'h00, 1'b0);
    nTests++; if ({countA, topA, nextA, emptyA} !== {4'd0, 8'h00, 8'h00, 1'b1}) begin
      nFail++; $display("[TB] FAIL clear got count=%0d top=%h next=%h empty=%b want 0 00 00 1", countA, topA, nextA, emptyA); end
    doCmd(PUSH, 8'h42, 1'b0);
    nTests++; if ({topA, nextA, countA} !== {8'h42, 8'h00, 4'd1}) begin
      nFail++; $display("[TB] FAIL clear_stale got top=%h next=%h count=%0d want 42 00 1", topA, nextA, countA); end
    doCmd(POP, 8'h00, 1'b0);
    doCmd(POP, 8'h00, 1'b0);
    reset = 1'b1;
    doCmd(PUSH, 8'h99, 1'b1);
    reset = 1'b0;
    nTests++; if ({countA, topA, nextA, emptyA, fullA, ovfA, unfA} !== {4'd0, 16'h0000, 4'b1000}) begin
      nFail++; $display("[TB] FAIL reset_mid got count=%0d top=%h next=%h e/f/o/u=%b want 0 00 00 1000",
                        countA, topA, nextA, {emptyA, fullA, ovfA, unfA}); end
  endtask

  task automatic test_random();
    logic [2:0] c;
    logic [7:0] d;
    logic clr, rst;
    logic [7:0] eTop, eNext;
    int r, n;
    doReset();
    mq.delete(); mOvf = 1'b0; mUnf = 1'b0;
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: c = PUSH;
        3, 4:    c = POP;
        5:       c = REPL;
        6:       c = DUP;
        7:       c = SWAP;
        8:       c = ($urandom_range(0, 3) == 0) ? CLR : NOP;
        default: c = NOP7;
      endcase
      d   = 8'($urandom);
      clr = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 99) == 0);
      reset = rst;
      doCmd(c, d, clr);
      reset = 1'b0;
      if (rst) begin mq.delete(); mOvf = 1'b0; mUnf = 1'b0; end
      else modelStep(c, d, clr);
      n = mq.size();
      eTop  = (n >= 1) ? mq[n-1] : 8'h00;
      eNext = (n >= 2) ? mq[n-2] : 8'h00;
      nTests++; if ({topA, nextA} !== {eTop, eNext}) begin
        nFail++; $display("[TB] FAIL rand%0d_data cmd=%0d got top=%h next=%h want %h %h", k, c, topA, nextA, eTop, eNext); end
      nTests++; if ({countA, emptyA, fullA} !== {4'(n), n == 0, n == DA}) begin
        nFail++; $display("[TB] FAIL rand%0d_count cmd=%0d got count=%0d e=%b f=%b want %0d", k, c, countA, emptyA, fullA, n); end
      nTests++; if ({ovfA, unfA} !== {mOvf, mUnf}) begin
        nFail++; $display("[TB] FAIL rand%0d_flags cmd=%0d got ovf=%b unf=%b want %b %b", k, c, ovfA, unfA, mOvf, mUnf); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_push_pop();
    test_swap_dup_repl();
    test_full();
    test_underflow();
    test_clear_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
